// File: rtl/seg_addsub_pkg.sv
// Shared types and helpers for the segmented add/subtract unit.
package seg_addsub_pkg;

    // Operation sequencing: wait for operands, walk the segments, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the segment counter for n segments; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seg_adder.sv
// SEG-bit ripple-carry adder slice, purely combinational.
module seg_adder #(
    parameter int SEG = 2
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    output logic [SEG-1:0] sum,
    output logic           c_out
);

    logic [SEG:0] w_c;

    assign w_c[0] = c_in;

    // One full adder per bit, carry rippling from bit 0 upwards.
    for (genvar i = 0; i < SEG; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign c_out = w_c[SEG];

endmodule

// File: rtl/seg_addsub.sv
// Multi-cycle unsigned add / two's-complement subtract, SEG bits per cycle.
//
// Handshake: an operand set is taken on a rising edge where in_valid=1 and
// in_ready=1 (in_ready is high only while idle). The result appears on out_n
// together with a one-cycle out_valid pulse exactly N cycles later; there is
// no backpressure on the result side. Inputs are ignored while busy.
module seg_addsub
    import seg_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEG   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_n0,
    input  logic [WIDTH-1:0] in_n1,
    input  logic             opt,
    output logic             out_valid,
    output logic [WIDTH:0]   out_n,
    output state_e           o_dbg_state
);

    localparam int N  = WIDTH / SEG;
    localparam int CW = cnt_width(N);

    if ((WIDTH < 2) || (SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_bad_param
        $error("seg_addsub: WIDTH must be >= 2 and a multiple of SEG");
    end

    state_e           r_state;
    state_e           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_opt;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_res;

    logic [SEG-1:0]   w_sum;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_top;

    // The low segment of the shifting operand registers is always the one in work.
    seg_adder #(
        .SEG (SEG)
    ) u_seg_adder (
        .a     (r_a[SEG-1:0]),
        .b     (r_b[SEG-1:0]),
        .c_in  (r_carry),
        .sum   (w_sum),
        .c_out (w_cout)
    );

    assign w_last    = (r_cnt == CW'(N - 1));
    // New sum bits enter at the top of the result; after N shifts segment 0 sits at bit 0.
    assign w_sum_top = WIDTH'(w_sum) << (WIDTH - SEG);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = CALC;
            CALC:    if (w_last)   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture and segment-serial accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_opt   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_n0;
                        // Subtract as A + ~B + 1; the +1 enters as the initial carry.
                        r_b     <= opt ? ~in_n1 : in_n1;
                        r_opt   <= opt;
                        r_carry <= opt;
                        r_cnt   <= '0;
                        r_res   <= '0;
                    end
                end
                CALC: begin
                    r_a                <= r_a >> SEG;
                    r_b                <= r_b >> SEG;
                    r_carry            <= w_cout;
                    r_cnt              <= r_cnt + CW'(1);
                    r_res[WIDTH-1:0]   <= (r_res[WIDTH-1:0] >> SEG) | w_sum_top;
                    // For subtract, a carry-out means no borrow, so the sign bit inverts.
                    if (w_last) begin
                        r_res[WIDTH] <= w_cout ^ r_opt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state and registers only.
    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign out_n       = (r_state == DONE) ? r_res : '0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg_addsub.sv
// Bench for seg_addsub: directed cases with literal results plus randomized
// traffic checked every cycle against an arithmetic reference.
module tb_seg_addsub;
    import seg_addsub_pkg::*;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int N  = W / S;
    localparam int OW = W + 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_n0;
    logic [W-1:0]  in_n1;
    logic          opt;
    logic          out_valid;
    logic [OW-1:0] out_n;
    state_e        dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cnt = 0;

    logic [OW-1:0] exp_q[$];
    int            due_q[$];

    seg_addsub #(
        .WIDTH (W),
        .SEG   (S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_n0       (in_n0),
        .in_n1       (in_n1),
        .opt         (opt),
        .out_valid   (out_valid),
        .out_n       (out_n),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [OW-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic op);
        logic [OW-1:0] ea;
        logic [OW-1:0] eb;
        ea = OW'(a);
        eb = OW'(b);
        return op ? (ea - eb) : (ea + eb);
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [OW-1:0] e;
        int            d;
        checks++;
        if (in_ready !== (exp_q.size() == 0)) begin
            errors++;
            $display("FAIL ready: cyc %0d got %b want %b", cyc, in_ready, (exp_q.size() == 0));
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid: cyc %0d out_n %h with nothing in flight", cyc, out_n);
            end else begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                if (out_n !== e) begin
                    errors++;
                    $display("FAIL result: cyc %0d got %h want %h", cyc, out_n, e);
                end
                checks++;
                if (cyc != d) begin
                    errors++;
                    $display("FAIL latency: result at cyc %0d want cyc %0d", cyc, d);
                end
            end
        end else begin
            checks++;
            if (out_n !== '0) begin
                errors++;
                $display("FAIL out_n_idle: cyc %0d got %h want 0", cyc, out_n);
            end
            if (exp_q.size() > 0 && cyc >= due_q[0]) begin
                errors++;
                $display("FAIL missing_valid: cyc %0d expected %h due at %0d", cyc, exp_q[0], due_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            due_q.delete();
        end else if (in_valid === 1'b1 && in_ready === 1'b1) begin
            exp_q.push_back(ref_model(in_n0, in_n1, opt));
            due_q.push_back(cyc + 1 + N);
            acc_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic scramble_inputs();
        in_n0 = W'($urandom);
        in_n1 = W'($urandom);
        opt   = 1'($urandom);
    endtask

    // Present an operand set until it is taken, then drop valid and scramble inputs.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         output bit ok);
        int n;
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_n0    = a;
        in_n1    = b;
        opt      = op;
        n = 0;
        while (!ok) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
            end else if (n > 4 * N + 10) begin
                break;
            end
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready never rose, cyc %0d", cyc);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Directed operation with a hand-computed expected result.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input logic [OW-1:0] exp_v, input string name);
        bit ok;
        bit got;
        issue(a, b, op, ok);
        if (!ok) return;
        got = 1'b0;
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got = 1'b1;
                checks++;
                if (out_n !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", name, out_n, exp_v);
                end
                checks++;
                if (c - 1 != N) begin
                    errors++;
                    $display("FAIL %s_latency: got %0d want %0d", name, c - 1, N);
                end
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: no out_valid within %0d cycles", name, N + 3);
            return;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: out_valid got %b want 0", name, out_valid);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < 4 * N + 10);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_timeout: in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        bit seen;
        int base;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_n0    = '0;
        in_n1    = '0;
        opt      = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state.
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++;
        if (out_n !== '0) begin errors++; $display("FAIL rst_out_n: got %h want 0", out_n); end
        checks++;
        if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases.
        do_op(8'd200, 8'd100, 1'b0, 9'h12C, "add_200_100");
        do_op(8'd5,   8'd9,   1'b1, 9'h1FC, "sub_5_9");
        do_op(8'd0,   8'd255, 1'b1, 9'h101, "sub_0_255");
        do_op(8'd255, 8'd255, 1'b1, 9'h000, "sub_255_255");
        do_op(8'd0,   8'd0,   1'b1, 9'h000, "sub_0_0");
        do_op(8'd255, 8'd255, 1'b0, 9'h1FE, "add_255_255");
        do_op(8'd255, 8'd0,   1'b1, 9'h0FF, "sub_255_0");
        do_op(8'd1,   8'd0,   1'b0, 9'h001, "add_1_0");

        // in_valid held high with operands changing every cycle.
        wait_idle();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_n0    = 8'd200;
        in_n1    = 8'd100;
        opt      = 1'b0;
        base     = acc_cnt;
        seen     = 1'b0;
        for (int c = 0; c < 2 * N + 8; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (out_n !== 9'h12C) begin
                    errors++;
                    $display("FAIL hold_first: got %h want %h", out_n, 9'h12C);
                end
            end
            @(posedge clk);
            #1;
            scramble_inputs();
        end
        in_valid = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL hold_first_missing: got no result want 1"); end
        checks++;
        if (acc_cnt - base < 2) begin
            errors++;
            $display("FAIL hold_second_accept: got %0d accepts want >= 2", acc_cnt - base);
        end

        // Reset in the second CALC cycle aborts the operation.
        wait_idle();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_n0    = 8'd0;
        in_n1    = 8'd255;
        opt      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", in_ready); end
        checks++;
        if (out_n !== '0) begin errors++; $display("FAIL abort_out_n: got %h want 0", out_n); end
        for (int c = 0; c < N + 3; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_valid: cyc %0d got %b want 0", cyc, out_valid);
            end
            @(negedge clk);
        end
        do_op(8'd7, 8'd3, 1'b1, 9'h004, "post_reset");

        // Randomized traffic with idle gaps, corner operands and rare resets.
        for (int i = 0; i < 1500; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            case ($urandom_range(0, 7))
                0:       a = '0;
                1:       a = '1;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                default: b = W'($urandom);
            endcase
            issue(a, b, 1'($urandom), ok);
            if ($urandom_range(0, 99) == 0) begin
                repeat ($urandom_range(0, N + 1)) @(posedge clk);
                pulse_reset();
            end
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog.
    initial begin
        #(800_000);
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_addsub.md
SEG_ADDSUB -- requirements
Module: seg_addsub

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, SHALL be >= 2.
REQ-002 Parameter SEG, default 2: bits processed per cycle; WIDTH % SEG SHALL be 0, checked at elaboration.
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1: reset, synchronous, active-low.
REQ-005 in_valid  input  1: operand set present.
REQ-006 in_ready  output  1: block idle, can accept operands.
REQ-007 in_n0  input  WIDTH: minuend/addend, unsigned.
REQ-008 in_n1  input  WIDTH: subtrahend/addend, unsigned.
REQ-009 opt  input  1: 0 = add, 1 = subtract.
REQ-010 out_valid  output  1: result pulse.
REQ-011 out_n  output  WIDTH+1: result.

Function
REQ-012 Let N = WIDTH/SEG; the FSM SHALL have states IDLE, CALC, DONE.
REQ-013 IDLE: in_ready=1; on in_valid=1, capture in_n0, in_n1, opt, clear segment counter, carry := opt; go CALC.
REQ-014 Operand B SHALL be stored as ~in_n1 when opt=1, in_n1 when opt=0.
REQ-015 CALC: each cycle add segment k (bits k*SEG+SEG-1 : k*SEG) of A and stored B plus registered carry; write SEG sum bits into result register; carry := segment carry-out; k increments.
REQ-016 After segment N-1 is processed, next state SHALL be DONE; CALC lasts exactly N cycles.
REQ-017 At the CALC-to-DONE edge, result bit WIDTH SHALL be final carry XOR opt.
REQ-018 out_n SHALL equal (in_n0 + (opt ? 2^(WIDTH+1) - in_n1 : in_n1)) mod 2^(WIDTH+1): unsigned sum for add, WIDTH+1-bit two's-complement difference for subtract.
REQ-019 DONE: out_valid=1 and out_n=result for exactly one cycle; next state IDLE unconditionally.
REQ-020 out_n SHALL be 0 whenever out_valid=0.
REQ-021 Latency: out_valid rises N cycles after the accepting edge; next acceptance no earlier than N+2 cycles after the previous one.
REQ-022 in_ready SHALL be 0 in CALC and DONE; in_valid and input changes in those states SHALL be ignored and SHALL NOT corrupt the operation in flight.
REQ-023 Captured operands SHALL be held internally; inputs need only be valid at the accepting edge.
REQ-024 All outputs SHALL be registered or decoded from state only (no input-to-output combinational path).

Reset
REQ-025 While rst_n=0 at a rising edge: state := IDLE, counter, carry, operand and result registers := 0.
REQ-026 Outputs after reset: in_ready=1, out_valid=0, out_n=0.
REQ-027 Reset asserted mid-CALC or in DONE SHALL abort the operation with no out_valid pulse.

Structure
REQ-028 Package seg_addsub_pkg SHALL hold the state enum (IDLE, CALC, DONE) and a function computing the counter width $clog2(N) (min 1).
REQ-029 Sub-module seg_adder (combinational, SEG-bit ripple full-adder chain: a, b, c_in -> sum, c_out) SHALL be instantiated once.
REQ-030 No arithmetic wider than SEG+1 bits SHALL be used in the datapath.

Verification (WIDTH=8, SEG=2, N=4)
REQ-031 Add 200 + 100, opt=0 -> out_valid 4 cycles after accept, out_n = 9'h12C, single-cycle pulse.
REQ-032 Sub 5 - 9, opt=1 -> out_n = 9'h1FC (-4); sub 0 - 255 -> 9'h101; sub 255 - 255 -> 9'h000; sub 0 - 0 -> 9'h000.
REQ-033 in_valid held high with changing operands during CALC -> first result unaffected, second operation accepted only when in_ready returns to 1.
REQ-034 rst_n pulled low during CALC cycle 2 -> no out_valid, in_ready=1 and out_n=0 the next cycle, new op afterwards correct.
REQ-035 Randomised 10k ops for WIDTH in {4,8,16} and SEG in {1,2,4} vs. REQ-018 reference model -> zero mismatches, latency exactly N every op.
